jelly_stream_unit_packer: RTL

Packs a unit-granular stream with partially filled beats (`s_count` valid units per beat) into dense, fully packed words of `M_NUM` units. Partial words are emitted only at packet ends. It sits directly upstream of `jelly_fifo_width_convert`: its `m_*` port drives that block's `s_*` port, so the FIFO only ever sees dense data plus a packet-end marker. Single clock domain.

---
 rtl/jelly_stream_unit_packer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/jelly_stream_unit_packer.sv
// ---------------------------------------------------------------------------
// jelly_stream_unit_packer
//
// Turns a stream of partly filled beats into dense words of M_NUM units.
// Each input beat carries s_count valid units, starting at unit 0. Units are
// collected in a small buffer and leave as full words. A shorter word is
// emitted only at a packet end, so the width converter downstream only ever
// sees dense data plus a packet-end marker.
//
// Ports:
//   reset    synchronous, active-low reset (0 = reset)
//   clk      clock
//   endian   0: unit 0 at the LSB, 1: unit 0 at the MSB (for both s_ and m_)
//   s_data   input units
//   s_count  valid units in the beat; values above S_NUM are clamped
//   s_last   beat ends a packet
//   s_valid  input valid
//   s_ready  input ready (depends on registered state and reset only)
//   m_data   packed output word; units at index >= m_count read as zero
//   m_count  valid units in the output word
//   m_last   output word ends a packet
//   m_valid  output valid
//   m_ready  output ready
// ---------------------------------------------------------------------------
module jelly_stream_unit_packer #(
   parameter int UNIT_WIDTH    = 8,
   parameter int S_NUM         = 4,
   parameter int M_NUM         = 4,
   parameter int S_COUNT_WIDTH = $clog2(S_NUM + 1),
   parameter int M_COUNT_WIDTH = $clog2(M_NUM + 1)
) (
   input  logic                          reset,
   input  logic                          clk,
   input  logic                          endian,
   input  logic [S_NUM*UNIT_WIDTH-1:0]   s_data,
   input  logic [S_COUNT_WIDTH-1:0]      s_count,
   input  logic                          s_last,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [M_NUM*UNIT_WIDTH-1:0]   m_data,
   output logic [M_COUNT_WIDTH-1:0]      m_count,
   output logic                          m_last,
   output logic                          m_valid,
   input  logic                          m_ready
);

   localparam int CAP        = M_NUM + S_NUM;
   localparam int FILL_WIDTH = $clog2(CAP + 1);

   // Index 0 of the buffer always holds the oldest unit, whatever the endian
   logic [UNIT_WIDTH-1:0]           unit_buf  [CAP];
   logic [UNIT_WIDTH-1:0]           buf_next  [CAP];
   logic [UNIT_WIDTH-1:0]           s_unit    [S_NUM];
   logic [FILL_WIDTH-1:0]           fill;
   logic                            last_pending;
   logic                            last_pending_next;
   logic                            s_fire;
   logic                            m_fire;
   int                              out_n;
   int                              in_n;
   int                              base;
   int                              next_fill;
   logic [M_NUM*UNIT_WIDTH-1:0]     m_data_next;

   // Input is taken only when a full beat is sure to fit after this cycle's
   // output shift. No packet-end word may still be waiting, which keeps
   // packets out of each other's output words.
   assign s_ready = reset && !last_pending && (int'(fill) <= M_NUM);
   assign s_fire  = s_valid && s_ready;
   assign m_fire  = m_valid && m_ready;

   // Split the input beat into units, numbered in stream order
   always_comb begin
      for (int i = 0; i < S_NUM; i++) begin
         if (endian) begin
            s_unit[i] = s_data[(S_NUM-1-i)*UNIT_WIDTH +: UNIT_WIDTH];
         end else begin
            s_unit[i] = s_data[i*UNIT_WIDTH +: UNIT_WIDTH];
         end
      end
   end

   // Next buffer contents. Any output word is shifted out first, then the
   // accepted units are appended at the new fill level. The selects are
   // written as compares against loop constants, so every array index stays
   // static and builds as plain muxes.
   always_comb begin
      out_n = 0;
      in_n  = 0;
      if (m_fire) begin
         out_n = (int'(fill) < M_NUM) ? int'(fill) : M_NUM;
      end
      if (s_fire) begin
         in_n = (int'(s_count) < S_NUM) ? int'(s_count) : S_NUM;
      end
      base      = int'(fill) - out_n;
      next_fill = base + in_n;
      for (int i = 0; i < CAP; i++) begin
         buf_next[i] = '0;
         for (int k = 0; k < CAP; k++) begin
            if (k == i + out_n) begin
               buf_next[i] = unit_buf[k];
            end
         end
         for (int j = 0; j < S_NUM; j++) begin
            if ((j < in_n) && (i == base + j)) begin
               buf_next[i] = s_unit[j];
            end
         end
      end
   end

   // Set and clear of the packet-end flag never coincide. Accepting needs
   // the flag clear, while an m_last fire needs it set.
   always_comb begin
      last_pending_next = last_pending;
      if (m_fire && m_last) begin
         last_pending_next = 1'b0;
      end
      if (s_fire && s_last) begin
         last_pending_next = 1'b1;
      end
   end

   // Output word from the next buffer state. Units beyond the valid count
   // are forced to zero so stale buffer contents never leak out.
   always_comb begin
      m_data_next = '0;
      for (int i = 0; i < M_NUM; i++) begin
         if (i < next_fill) begin
            if (endian) begin
               m_data_next[(M_NUM-1-i)*UNIT_WIDTH +: UNIT_WIDTH] = buf_next[i];
            end else begin
               m_data_next[i*UNIT_WIDTH +: UNIT_WIDTH] = buf_next[i];
            end
         end
      end
   end

   // State and registered outputs. The m_* registers are loaded from the
   // next state, so they always describe the buffer as it stands after the
   // edge. They stay unchanged while a word is stalled by m_ready.
   always_ff @(posedge clk) begin
      if (!reset) begin
         fill         <= '0;
         last_pending <= 1'b0;
         m_valid      <= 1'b0;
         m_data       <= '0;
         m_count      <= '0;
         m_last       <= 1'b0;
         for (int i = 0; i < CAP; i++) begin
            unit_buf[i] <= '0;
         end
      end else begin
         fill         <= FILL_WIDTH'(next_fill);
         last_pending <= last_pending_next;
         m_valid      <= (next_fill >= M_NUM) || last_pending_next;
         m_data       <= m_data_next;
         m_count      <= M_COUNT_WIDTH'((next_fill < M_NUM) ? next_fill : M_NUM);
         m_last       <= last_pending_next && (next_fill <= M_NUM);
         for (int i = 0; i < CAP; i++) begin
            unit_buf[i] <= buf_next[i];
         end
      end
   end

endmodule
